// File: rtl/idex_hazard_if.sv
// Signal bundle between the ID/EX pipeline datapath and the hazard controller.
// slave = hazard controller, master = pipeline side.
interface idex_hazard_if #(
   parameter int CNT_W = 16
);
   logic             idex_mem_read;
   logic [4:0]       idex_rt;
   logic             idex_branch;
   logic             ex_zero;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output idex_mem_read, idex_rt, idex_branch, ex_zero, id_rs, id_rt, id_uses_rt,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, stall_count, flush_count
   );

   modport slave (
      input  idex_mem_read, idex_rt, idex_branch, ex_zero, id_rs, id_rt, id_uses_rt,
      output pc_write, ifid_write, ifid_flush, idex_bubble, stall_count, flush_count
   );
endinterface

// File: rtl/idex_hazard_ctrl.sv
// Load-use stall / taken-branch flush controller for the ID/EX register.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush counters.
module idex_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic          clk,
   input  logic          reset,
   idex_hazard_if.slave  hz
);
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

   state_t     r_state;
   logic [2:0] r_fcnt;

   logic w_taken;
   logic w_lu_hit;
   logic w_flush_evt;
   logic w_stall_evt;

   assign w_taken  = hz.idex_branch & hz.ex_zero;
   assign w_lu_hit = hz.idex_mem_read & (hz.idex_rt != 5'd0) &
                     ((hz.idex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.idex_rt == hz.id_rt)));

   // FLUSH ignores both causes: the controls they would act on are already bubbles
   assign w_flush_evt = w_taken & (r_state != ST_FLUSH);
   assign w_stall_evt = w_lu_hit & ~w_taken & (r_state == ST_RUN);

   // Hazard responses, combinational so they act in the same cycle as their cause
   always_comb begin
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b0;
      if (reset) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.ifid_flush  = 1'b1;
         hz.idex_bubble = 1'b1;
      end else if ((r_state == ST_FLUSH) || w_flush_evt) begin
         hz.ifid_flush  = 1'b1;
         hz.idex_bubble = 1'b1;
      end else if (w_stall_evt) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.idex_bubble = 1'b1;
      end else begin
         hz.pc_write    = 1'b1;
      end
   end

   // State machine and flush down-counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_fcnt  <= 3'd0;
      end else begin
         case (r_state)
            ST_RUN, ST_STALL: begin
               if (w_flush_evt) begin
                  if (FLUSH_CYCLES > 1) begin
                     r_state <= ST_FLUSH;
                     r_fcnt  <= FC_INIT;
                  end else begin
                     r_state <= ST_RUN;
                     r_fcnt  <= 3'd0;
                  end
               end else if (w_stall_evt) begin
                  r_state <= ST_STALL;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_FLUSH: begin
               r_fcnt <= r_fcnt - 3'd1;
               if (r_fcnt <= 3'd1) begin
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_FLUSH;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_fcnt  <= 3'd0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign hz.stall_count = r_stall_cnt;
   assign hz.flush_count = r_flush_cnt;
`else
   assign hz.stall_count = {CNT_W{1'b0}};
   assign hz.flush_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Directed bench for idex_hazard_ctrl: a default instance plus a CNT_W=2 instance
// sharing the same stimulus for the counter saturation check.
module tb_idex_hazard_ctrl;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Output patterns {pc_write, ifid_write, ifid_flush, idex_bubble}
   localparam logic [3:0] O_RST   = 4'b0011;
   localparam logic [3:0] O_RUN   = 4'b1100;
   localparam logic [3:0] O_STALL = 4'b0001;
   localparam logic [3:0] O_FLUSH = 4'b1111;

   idex_hazard_if #(.CNT_W(16)) hz ();
   idex_hazard_if #(.CNT_W(2))  hz2 ();

   idex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   idex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .hz    (hz2.slave)
   );

   assign hz2.idex_mem_read = hz.idex_mem_read;
   assign hz2.idex_rt       = hz.idex_rt;
   assign hz2.idex_branch   = hz.idex_branch;
   assign hz2.ex_zero       = hz.ex_zero;
   assign hz2.id_rs         = hz.id_rs;
   assign hz2.id_rt         = hz.id_rt;
   assign hz2.id_uses_rt    = hz.id_uses_rt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic mr, input logic [4:0] xrt, input logic br, input logic z,
                         input logic [4:0] rs, input logic [4:0] rt, input logic use_rt);
      hz.idex_mem_read = mr;
      hz.idex_rt       = xrt;
      hz.idex_branch   = br;
      hz.ex_zero       = z;
      hz.id_rs         = rs;
      hz.id_rt         = rt;
      hz.id_uses_rt    = use_rt;
   endtask

   // Let combinational outputs settle, check them, then move to 1 ns after the next edge
   task automatic chk(input string tag, input logic [3:0] exp_o);
      #2;
      cmp(tag, {28'd0, hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble}, {28'd0, exp_o});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int s, input int f);
      cmp({tag, "_stall"}, {16'd0, hz.stall_count}, PERF ? 32'(s) : 32'd0);
      cmp({tag, "_flush"}, {16'd0, hz.flush_count}, PERF ? 32'(f) : 32'd0);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b1;
      set_in(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
      #1;
      // 1. reset held three cycles, then released
      chk("rst_c0", O_RST);
      chk("rst_c1", O_RST);
      chk("rst_c2", O_RST);
      reset = 1'b0;
      chk_cnt("rst", 0, 0);
      chk("post_rst", O_RUN);
      // 2. load-use on rs
      set_in(1'b1, 5'd8, 1'b0, 1'b0, 5'd8, 5'd0, 1'b0);
      chk("lu_rs", O_STALL);
      chk("lu_in_stall_ignored", O_RUN);
      chk_cnt("after_lu", 1, 0);
      set_in(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
      chk("run_after_stall", O_RUN);
      // 3. rt==0 and unused-rt matches do not stall
      set_in(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
      chk("rt_zero", O_RUN);
      set_in(1'b1, 5'd9, 1'b0, 1'b0, 5'd3, 5'd9, 1'b0);
      chk("rt_unused", O_RUN);
      chk_cnt("no_stall", 1, 0);
      set_in(1'b1, 5'd9, 1'b0, 1'b0, 5'd3, 5'd9, 1'b1);
      chk("lu_rt", O_STALL);
      set_in(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
      chk_cnt("after_lu_rt", 2, 0);
      chk("stall_exit", O_RUN);
      // 4. taken branch flushes for two cycles; not-taken does nothing
      set_in(1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
      chk("not_taken", O_RUN);
      set_in(1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
      chk("taken", O_FLUSH);
      set_in(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
      chk("flush_c2", O_FLUSH);
      chk_cnt("after_flush", 2, 1);
      chk("flush_done", O_RUN);
      // 5. taken beats lu_hit; hazards ignored in FLUSH
      set_in(1'b1, 5'd8, 1'b1, 1'b1, 5'd8, 5'd0, 1'b0);
      chk("taken_and_lu", O_FLUSH);
      chk("flush_ignores", O_FLUSH);
      chk_cnt("prio", 2, 2);
      set_in(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
      chk("prio_done", O_RUN);
      // taken seen in STALL
      set_in(1'b1, 5'd4, 1'b0, 1'b0, 5'd4, 5'd0, 1'b0);
      chk("lu_before_taken", O_STALL);
      set_in(1'b1, 5'd4, 1'b1, 1'b1, 5'd4, 5'd0, 1'b0);
      chk("taken_in_stall", O_FLUSH);
      set_in(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
      chk("stall_flush_c2", O_FLUSH);
      chk_cnt("stall_taken", 3, 3);
      chk("stall_flush_done", O_RUN);
      // reset during FLUSH
      set_in(1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
      chk("taken_pre_rst", O_FLUSH);
      set_in(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
      reset = 1'b1;
      chk("rst_in_flush", O_RST);
      reset = 1'b0;
      chk_cnt("rst_clear", 0, 0);
      chk("run_after_rst", O_RUN);
      // 6. five stalls: 16-bit counts 5, 2-bit saturates at 3
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 5'd12, 1'b0, 1'b0, 5'd12, 5'd0, 1'b0);
         chk("sat_lu", O_STALL);
         set_in(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
         chk("sat_exit", O_RUN);
      end
      chk_cnt("five_stalls", 5, 0);
      cmp("sat_stall_w2", {30'd0, hz2.stall_count}, PERF ? 32'd3 : 32'd0);
      cmp("sat_flush_w2", {30'd0, hz2.flush_count}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
